// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - opcode encodings, datapath widths and writing-opcode decode
package writeback_stage_pkg;

    localparam int OPCODE_WIDTH  = 8;
    localparam int REG_WIDTH     = 16;
    localparam int IDX_WIDTH     = 4;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_CNT_WIDTH = 2;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD_D  = 8'h00,
        OP_ADDI_D = 8'h01,
        OP_AND_D  = 8'h02,
        OP_ANDI_D = 8'h03,
        OP_MOV    = 8'h04,
        OP_MOVI_D = 8'h05,
        OP_LDW    = 8'h06,
        OP_STW    = 8'h07,
        OP_BRN    = 8'h08,
        OP_JMP    = 8'h09,
        OP_JSR    = 8'h0A,
        OP_JSRR   = 8'h0B,
        OP_RET    = 8'h0C,
        OP_NOP    = 8'hFF
    } opcode_e;

    function automatic logic is_writing_op(input logic [OPCODE_WIDTH-1:0] op);
        logic w;
        case (op)
            OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D,
            OP_MOV, OP_MOVI_D, OP_LDW, OP_JSR, OP_JSRR: w = 1'b1;
            default:                                    w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - memory-stage input bundle and register-file/scoreboard outputs
interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int RETIRE_WIDTH = 16
);
    logic                    I_LOCK;
    logic                    I_FetchStall;
    logic                    I_DepStall;
    logic [OPCODE_WIDTH-1:0] I_Opcode;
    logic [REG_WIDTH-1:0]    I_ALUOut;
    logic [REG_WIDTH-1:0]    I_MemOut;
    logic [IDX_WIDTH-1:0]    I_DestRegIdx;
    logic                    I_SbSetValid;
    logic [IDX_WIDTH-1:0]    I_SbSetIdx;
    logic                    O_WriteEnable;
    logic [IDX_WIDTH-1:0]    O_WriteRegIdx;
    logic [REG_WIDTH-1:0]    O_WriteValue;
    logic [NUM_REGS-1:0]     O_BusyVec;
    logic                    O_SbError;
    logic [RETIRE_WIDTH-1:0] O_RetireCount;

    modport master (
        output I_LOCK, I_FetchStall, I_DepStall, I_Opcode, I_ALUOut, I_MemOut,
               I_DestRegIdx, I_SbSetValid, I_SbSetIdx,
        input  O_WriteEnable, O_WriteRegIdx, O_WriteValue, O_BusyVec, O_SbError,
               O_RetireCount
    );

    modport slave (
        input  I_LOCK, I_FetchStall, I_DepStall, I_Opcode, I_ALUOut, I_MemOut,
               I_DestRegIdx, I_SbSetValid, I_SbSetIdx,
        output O_WriteEnable, O_WriteRegIdx, O_WriteValue, O_BusyVec, O_SbError,
               O_RetireCount
    );
endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-write counters, busy vector and sticky error
module wb_scoreboard
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_valid,
    input  logic [IDX_WIDTH-1:0] set_idx,
    input  logic                 clr_valid,
    input  logic [IDX_WIDTH-1:0] clr_idx,
    output logic [NUM_REGS-1:0]  busy_vec,
    output logic                 sb_error
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt      [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_next [NUM_REGS];
    logic                 err_now;

    // A set and a clear on the same register cancel, so neither can overflow or underflow.
    always_comb begin
        err_now = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            logic inc, dec;
            cnt_next[i] = cnt[i];
            inc = set_valid && (set_idx == IDX_WIDTH'(i));
            dec = clr_valid && (clr_idx == IDX_WIDTH'(i));
            if (inc && !dec) begin
                if (cnt[i] == CNT_MAX) err_now = 1'b1;
                else                   cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
            end else if (dec && !inc) begin
                if (cnt[i] == '0)      err_now = 1'b1;
                else                   cnt_next[i] = cnt[i] - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            busy_vec <= '0;
            sb_error <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i]      <= cnt_next[i];
                busy_vec[i] <= (cnt_next[i] != '0);
            end
            sb_error <= sb_error | err_now;
        end
    end
endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - result select, register-file write port and retire counter
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET,
    writeback_stage_if.slave  bus
);
    logic                    inst_valid;
    logic                    inst_writes;
    logic [REG_WIDTH-1:0]    result;
    logic                    write_enable;
    logic [IDX_WIDTH-1:0]    write_reg_idx;
    logic [REG_WIDTH-1:0]    write_value;
    logic [RETIRE_WIDTH-1:0] retire_count;
    logic [NUM_REGS-1:0]     busy_vec;
    logic                    sb_error;

    assign inst_valid  = bus.I_LOCK && !bus.I_FetchStall && !bus.I_DepStall;
    assign inst_writes = inst_valid && is_writing_op(bus.I_Opcode);
    assign result      = (bus.I_Opcode == OP_LDW) ? bus.I_MemOut : bus.I_ALUOut;

    // Index and value hold between writes so the register-file port is stable on bubbles.
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            write_enable  <= 1'b0;
            write_reg_idx <= '0;
            write_value   <= '0;
            retire_count  <= '0;
        end else begin
            write_enable <= inst_writes;
            if (inst_writes) begin
                write_reg_idx <= bus.I_DestRegIdx;
                write_value   <= result;
            end
            if (inst_valid) retire_count <= retire_count + RETIRE_WIDTH'(1);
        end
    end

    wb_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_scoreboard (
        .clk       (I_CLOCK),
        .rst       (I_RESET),
        .set_valid (bus.I_SbSetValid),
        .set_idx   (bus.I_SbSetIdx),
        .clr_valid (inst_writes),
        .clr_idx   (bus.I_DestRegIdx),
        .busy_vec  (busy_vec),
        .sb_error  (sb_error)
    );

    assign bus.O_WriteEnable = write_enable;
    assign bus.O_WriteRegIdx = write_reg_idx;
    assign bus.O_WriteValue  = write_value;
    assign bus.O_RetireCount = retire_count;
    assign bus.O_BusyVec     = busy_vec;
    assign bus.O_SbError     = sb_error;
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 16, giving the number of architectural registers tracked.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 2, giving the width of each pending-write counter.
REQ-003 The block SHALL have parameter RETIRE_WIDTH, default 16, giving the width of the retired-instruction counter.
REQ-004 The block SHALL have port I_CLOCK, input, 1 bit: the single clock, with all state updating on its falling edge.
REQ-005 The block SHALL have port I_RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port I_LOCK, input, 1 bit: pipeline enable from the memory stage.
REQ-007 The block SHALL have ports I_FetchStall and I_DepStall, input, 1 bit each: bubble markers from the memory stage.
REQ-008 The block SHALL have port I_Opcode, input, `OPCODE_WIDTH: the opcode of the instruction leaving memory.
REQ-009 The block SHALL have ports I_ALUOut and I_MemOut, input, `REG_WIDTH each: the ALU result and the load data.
REQ-010 The block SHALL have port I_DestRegIdx, input, 4 bits: the destination register.
REQ-011 The block SHALL have ports I_SbSetValid (1 bit) and I_SbSetIdx (4 bits), input: decode marks a register as having a pending write.
REQ-012 The block SHALL have ports O_WriteEnable (1), O_WriteRegIdx (4) and O_WriteValue (`REG_WIDTH), output: the register-file write port.
REQ-013 The block SHALL have port O_BusyVec, output, NUM_REGS bits: bit i is 1 while register i has one or more pending writes.
REQ-014 The block SHALL have port O_SbError, output, 1 bit: sticky scoreboard overflow/underflow flag.
REQ-015 The block SHALL have port O_RetireCount, output, RETIRE_WIDTH bits: count of instructions retired.

Function
REQ-016 On each falling edge of I_CLOCK, the block SHALL treat an instruction as valid when I_LOCK=1, I_FetchStall=0 and I_DepStall=0; any other input combination is a bubble.
REQ-017 The writing opcodes SHALL be ADD_D, ADDI_D, AND_D, ANDI_D, MOV, MOVI_D, LDW, JSR and JSRR; every other valid opcode SHALL retire without a register write.
REQ-018 For a valid writing opcode, the block SHALL assert O_WriteEnable=1 for exactly one cycle after that edge, with O_WriteRegIdx=I_DestRegIdx.
REQ-019 O_WriteValue SHALL be I_MemOut for LDW and I_ALUOut for all other writing opcodes.
REQ-020 For a bubble or a non-writing opcode, O_WriteEnable SHALL be 0 and O_WriteRegIdx/O_WriteValue SHALL hold their previous values.
REQ-021 The block SHALL keep one CNT_WIDTH-bit pending counter per register.
REQ-022 When I_SbSetValid=1, the counter selected by I_SbSetIdx SHALL increment by 1.
REQ-023 A valid writing instruction SHALL decrement the counter selected by I_DestRegIdx by 1.
REQ-024 When the set and the clear hit the same index in the same cycle, that counter SHALL be unchanged.
REQ-025 When the set and the clear hit different indices in the same cycle, both updates SHALL apply.
REQ-026 An increment of a counter at its maximum (3) SHALL hold the counter and set O_SbError.
REQ-027 A decrement of a counter at 0 SHALL hold the counter and set O_SbError.
REQ-028 Once set, O_SbError SHALL stay 1 until reset.
REQ-029 O_BusyVec[i] SHALL be registered and SHALL equal (counter[i] != 0) after each edge.
REQ-030 O_BusyVec SHALL reflect an I_SbSetValid pulse on the edge that samples it, so decode sees the register busy in the next cycle.
REQ-031 O_RetireCount SHALL increment by 1 for every valid instruction, writing or not, and SHALL wrap from all-ones to 0.
REQ-032 While I_LOCK=0, the block SHALL make no register writes, O_RetireCount SHALL hold, and scoreboard sets from decode SHALL still be accepted.
REQ-033 Latency from a valid instruction at the input to O_WriteEnable SHALL be one edge.

Reset
REQ-034 Asserting I_RESET SHALL immediately, without waiting for a clock edge, force: O_WriteEnable=0, O_WriteRegIdx=0, O_WriteValue=0, all counters=0, O_BusyVec=0, O_SbError=0, O_RetireCount=0.
REQ-035 A reset asserted during a write SHALL cancel that write.
REQ-036 The first edge after I_RESET deasserts SHALL process inputs normally.

Structure
REQ-037 The writing-opcode list and the NUM_REGS/CNT_WIDTH defaults SHALL live in global_def.h alongside the existing opcode defines.
REQ-038 The scoreboard SHALL be one sub-module, wb_scoreboard, containing the counters, the busy vector and the error flag.
REQ-039 Result selection and the retire counter SHALL remain in writeback_stage.

Verification
REQ-040 Bench case: valid ADD_D with I_ALUOut=16'h1234 and I_DestRegIdx=5 -> O_WriteEnable=1 for one cycle, O_WriteRegIdx=5, O_WriteValue=16'h1234, O_RetireCount=1.
REQ-041 Bench case: valid LDW with I_MemOut=16'hBEEF, I_ALUOut=16'h0010 and I_DestRegIdx=3 -> O_WriteValue=16'hBEEF.
REQ-042 Bench case: valid STW, then a bubble (I_DepStall=1) carrying an ADD_D -> O_WriteEnable stays 0 throughout, and O_RetireCount increments only for the STW.
REQ-043 Bench case: set on register 7 twice -> O_BusyVec[7]=1; then a set and a clear on register 7 in the same cycle -> O_BusyVec[7] stays 1; then two clears -> O_BusyVec[7]=0 and O_SbError=0.
REQ-044 Bench case: four sets on register 2 -> O_SbError=1 after the fourth; a clear on register 9 while its counter is 0 (after reset) -> O_SbError=1.
REQ-045 Bench case: O_RetireCount preloaded to 16'hFFFF via 65535 retirements, then one more -> O_RetireCount=0; I_RESET pulsed between clock edges -> all outputs read 0 before the next edge.
